// File: rtl/counter_monitor.sv
// counter_monitor
//   Receive-side checker for the wrap counter stream (count, count_inv).
//   Each value is predicted with next(v) = (v >= 10) ? v - 8 : v + 1.
//   The monitor moves through three states: HUNT (no reference), SYNC
//   (building a run of correct predictions) and LOCKED. While LOCKED it
//   flags bad samples and tallies them in a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         sample valid; count/count_inv are ignored when low
//   count      observed counter value (W bits)
//   count_inv  observed inverted value; must equal ~count
//   clr_err    synchronous clear of err_count (wins over an increment)
//   locked     monitor is locked to the sequence
//   err        one-cycle pulse per bad sample while LOCKED
//   inv_err    one-cycle pulse per sample with count_inv != ~count
//   err_count  saturating count of err pulses (EW bits)
//   expected   current prediction of the next sample (W bits)
module counter_monitor #(
  parameter int W        = 8,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int EW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  count,
  input  logic [W-1:0]  count_inv,
  input  logic          clr_err,
  output logic          locked,
  output logic          err,
  output logic          inv_err,
  output logic [EW-1:0] err_count,
  output logic [W-1:0]  expected
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Sequence rule shared by every prediction; W >= 4 keeps both branches
  // free of wrap-around.
  function automatic logic [W-1:0] next_val(input logic [W-1:0] v);
    return (v >= W'(10)) ? v - W'(8) : v + W'(1);
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    expected_q, expected_d;
  logic [MW-1:0]   match_cnt_q, match_cnt_d;
  logic [UW-1:0]   miss_cnt_q, miss_cnt_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            inv_err_q, inv_err_d;
  logic [EW-1:0]   err_count_q, err_count_d;

  logic            inv_ok;
  logic            match;

  assign inv_ok = (count_inv == ~count);
  assign match  = (count == expected_q);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    inv_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (en) begin
      inv_err_d = !inv_ok;
      unique case (state_q)
        HUNT: begin
          if (inv_ok) begin
            expected_d  = next_val(count);
            match_cnt_d = '0;
            state_d     = SYNC;
          end
        end
        SYNC: begin
          if (!inv_ok) begin
            state_d = HUNT;
          end else if (match) begin
            expected_d  = next_val(expected_q);
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == MW'(LOCK_N - 1)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            // Trusted inverse but wrong value: restart the run from here.
            expected_d  = next_val(count);
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Prediction free-runs; a bad sample never re-seeds it.
          expected_d = next_val(expected_q);
          if (inv_ok && match) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_cnt_q + 1'b1;
            if (miss_cnt_q == UW'(UNLOCK_N - 1)) begin
              state_d    = HUNT;
              miss_cnt_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr_err) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      inv_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      inv_err_q   <= inv_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign inv_err   = inv_err_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
Receive-side checker for the wrap counter sequence (count, count_inv) produced on the counter interface. Predicts each next value with the same rule: next = (v >= 10) ? v - 8 : v + 1. Acquires lock on the stream, flags sequence and inversion errors, and keeps an error tally for status readout. Sits downstream of the counter, in the same clk domain, and observes samples qualified by en.

Parameters:
W, 8, width of count/count_inv/expected; must be >= 4 so v + 1 and v - 8 never wrap.
LOCK_N, 4, consecutive correct predictions needed to enter LOCKED (>= 1).
UNLOCK_N, 2, consecutive bad samples in LOCKED that force return to HUNT (>= 1).
EW, 16, width of err_count.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
en  input  1  sample valid; count/count_inv are ignored when 0.
count  input  W  observed counter value.
count_inv  input  W  observed inverted value; must equal ~count.
clr_err  input  1  synchronous clear of err_count.
locked  output  1  monitor is locked to the sequence.
err  output  1  one-cycle pulse per bad sample while LOCKED.
inv_err  output  1  one-cycle pulse per sample with count_inv != ~count, in any state.
err_count  output  EW  saturating count of err pulses.
expected  output  W  current prediction of the next sample.

Behaviour:
- rst asserted: immediately and asynchronously go to HUNT. locked=0, err=0, inv_err=0, err_count=0, expected=0, match_cnt=0, miss_cnt=0. This applies at any time, including mid-LOCKED.
- All outputs are registered. Each response appears on the clk edge that samples en=1, so it is visible in the cycle after the input.
- en=0: state, expected and counters hold. err and inv_err are 0.
- A sample is good when inv_ok (count_inv == ~count) and count == expected.
- inv_err pulses for every en=1 sample with !inv_ok, in any state.
- HUNT, on a sample with inv_ok: expected = next(count), match_cnt = 0, go to SYNC. On !inv_ok: stay in HUNT.
- SYNC, on a good sample: expected = next(expected), match_cnt++. When match_cnt reaches LOCK_N, go to LOCKED, set locked=1, and set miss_cnt=0.
- SYNC, on an inv_ok mismatch: expected = next(count), match_cnt = 0, stay in SYNC.
- SYNC, on !inv_ok: go to HUNT.
- LOCKED, on a good sample: expected = next(expected), miss_cnt = 0.
- LOCKED, on a bad sample (mismatch or !inv_ok):
  - err=1 and err_count++.
  - expected = next(expected); the prediction free-runs and does not resync to the bad value.
  - miss_cnt++. When miss_cnt reaches UNLOCK_N, go to HUNT and set locked=0 on the same edge.
- err_count saturates at 2^EW - 1.
- clr_err sets err_count to 0 on the next edge. If clr_err coincides with an increment, clear wins and the result is 0.
- next() arithmetic is done in W bits. Because W >= 4, neither operation overflows or underflows. Values >= 10 step down by 8 until they fall below 10.
- err never asserts outside LOCKED.
- locked changes only on en=1 edges or on rst.

Test Plan:
- Lock: rst, then en=1 with count 0,1,2,3,4 and valid inverse -> locked=1 on the cycle after sample 4; expected=5; err_count=0.
- Wrap: locked at 8, then feed 9,10,2,3 -> expected shows 10,2,3,4; no err and no inv_err.
- Single glitch: locked, feed 5, 0x66 (should be 6), 7 -> one err pulse; err_count=1; locked stays 1; 7 matches.
- Inversion fault: locked, feed count=3 with count_inv=0x00 -> err=1 and inv_err=1 in the same cycle; err_count increments.
- Unlock and relock: feed two consecutive wrong values -> err_count=2 and locked=0 after the second; then 5 good samples -> locked=1 again.
- Reset and clear: async rst mid-LOCKED -> all outputs 0 before the next clk edge. Then drive clr_err together with a bad sample -> err_count=0.
